pedes_request: RTL and testbench
================================

Name: pedes_request

Overview:
- Pedestrian push-button front end, directly upstream of the traffic light controller FSM.
- Synchronises and debounces the raw button, qualifying it against the shared timebase tick.
- Latches one pending crossing request per green-pedestrian cycle and raises an URGENT flag when a request waits too long.
- REQ and URGENT feed the controller FSM; G_PEDES returns from the controller as the service acknowledge.

Parameters:
- SYNC_STAGES, 2: number of synchroniser flops on BUTTON (minimum 2).
- DEB_TICKS, 4: consecutive TC_TIMEBASE ticks of a stable new level needed to accept a button level change (minimum 1).
- MAX_WAIT, 20: TC_TIMEBASE ticks a request may stay pending before URGENT asserts (minimum 1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- TC_TIMEBASE  in  1  one-cycle timebase tick from the timebase generator.
- BUTTON  in  1  raw asynchronous pedestrian button, active-high, may bounce.
- G_PEDES  in  1  pedestrian green from the controller FSM; serves as the acknowledge.
- PRESS  out  1  one-cycle pulse on each debounced rising edge.
- REQ  out  1  pending crossing request to the controller FSM.
- URGENT  out  1  pending request has waited MAX_WAIT ticks.

Behaviour:
- Reset: RST low asynchronously clears all of the following to 0: synchroniser flops, debounced level btn_db, debounce counter, wait counter, PRESS, REQ, URGENT. The FSM goes to IDLE.
- Synchroniser: BUTTON passes through SYNC_STAGES flops to give btn_s.
- Debounce counter, width clog2(DEB_TICKS+1):
  - Clears in any cycle where btn_s == btn_db.
  - Otherwise increments on each TC_TIMEBASE cycle.
  - On the tick that brings it to DEB_TICKS: btn_db toggles and the counter clears.
- PRESS: registered. It is high for exactly the one cycle after btn_db rises 0->1. A falling edge produces no pulse.
- FSM state IDLE:
  - Outputs REQ=0, URGENT=0.
  - G_PEDES=1 -> SERVING. This has priority over PRESS, so the press is discarded.
  - Else PRESS=1 -> PENDING, and the wait counter clears.
- FSM state PENDING:
  - REQ=1.
  - Wait counter (width clog2(MAX_WAIT+1)) increments on each TC_TIMEBASE and saturates at MAX_WAIT.
  - URGENT=1 while the wait counter == MAX_WAIT.
  - Further PRESS pulses are ignored; the request does not stack.
  - G_PEDES=1 -> SERVING.
- FSM state SERVING:
  - REQ=0, URGENT=0.
  - PRESS is ignored and never latched retroactively.
  - G_PEDES=0 -> IDLE.
- REQ and URGENT are registered and reflect the state/counter one cycle after a transition:
  - REQ rises the cycle after PRESS.
  - REQ and URGENT fall the cycle after G_PEDES is first sampled high.
- Latency, BUTTON rise to PRESS: SYNC_STAGES cycles, then DEB_TICKS qualifying ticks, then 1 cycle.
- Boundaries:
  - TESTMODE affects only the tick rate; this block has no mode input.
  - A button held through reset release is re-qualified as a fresh press after DEB_TICKS ticks.
  - The wait counter never wraps.

Test Plan:
1. Clean press with DEB_TICKS=4, tick every 10 clocks, BUTTON held 80 clocks -> single PRESS pulse after the 4th qualifying tick; REQ=1 the next cycle and held; URGENT=0.
2. Bounce of 3-tick high bursts separated by lows -> no PRESS; REQ stays 0; debounce counter returns to 0.
3. Pending request, G_PEDES held 0 for 25 ticks, MAX_WAIT=20 -> URGENT rises one cycle after the 20th tick and stays 1; G_PEDES raised -> REQ and URGENT both 0 the next cycle; state SERVING.
4. Press while G_PEDES=1, then G_PEDES drops -> PRESS pulses but REQ stays 0 throughout and after the return to IDLE.
5. PRESS and G_PEDES rising in the same cycle from IDLE -> state SERVING; REQ never asserts.
6. RST pulsed low mid-PENDING with BUTTON held -> REQ, URGENT and PRESS go 0 immediately (before the next clock edge); after release, PRESS re-fires after 4 ticks and REQ=1 one cycle later.

Source files
------------

// File: rtl/pedes_request_if.sv
// Pedestrian request bus: timebase tick, raw button and controller acknowledge in;
// debounced press pulse, pending request and urgency flag out.
interface pedes_request_if;
  logic TC_TIMEBASE;
  logic BUTTON;
  logic G_PEDES;
  logic PRESS;
  logic REQ;
  logic URGENT;

  modport master (
    output TC_TIMEBASE, BUTTON, G_PEDES,
    input  PRESS, REQ, URGENT
  );

  modport slave (
    input  TC_TIMEBASE, BUTTON, G_PEDES,
    output PRESS, REQ, URGENT
  );
endinterface

// File: rtl/pedes_request.sv
// Pedestrian push-button front end: synchronise, debounce on timebase ticks, latch a
// single crossing request until the pedestrian green acknowledges it, flag long waits.
module pedes_request #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_TICKS   = 4,
  parameter int MAX_WAIT    = 20
) (
  input logic           CLK,
  input logic           RST,
  pedes_request_if.slave bus
);

  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   btn_s;
  logic                   btn_db_q;
  logic                   btn_db_d;
  logic [DW-1:0]          deb_cnt_q;
  logic [DW-1:0]          deb_cnt_d;
  logic                   press_q;
  logic                   press_d;
  state_t                 state_q;
  logic [WW-1:0]          wait_q;
  logic [WW-1:0]          wait_inc;
  logic                   req_q;
  logic                   urgent_q;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.BUTTON};
  assign btn_s    = sync_q[SYNC_STAGES-1];
  assign wait_inc = wait_q + WW'(1);

  // Debounce: a differing level must survive DEB_TICKS ticks; any agreement restarts the count.
  always_comb begin
    btn_db_d  = btn_db_q;
    deb_cnt_d = deb_cnt_q;
    press_d   = 1'b0;
    if (btn_s == btn_db_q) begin
      deb_cnt_d = '0;
    end else if (bus.TC_TIMEBASE) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d  = ~btn_db_q;
        deb_cnt_d = '0;
        press_d   = ~btn_db_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
  end

  // Synchroniser, debounced level and press pulse registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q    <= '0;
      btn_db_q  <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      btn_db_q  <= btn_db_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
    end
  end

  // Request FSM; REQ/URGENT are registered alongside the state so they track it one cycle late.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      req_q    <= 1'b0;
      urgent_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          urgent_q <= 1'b0;
          if (bus.G_PEDES) begin
            state_q <= SERVING;
            req_q   <= 1'b0;
          end else if (press_q) begin
            state_q <= PENDING;
            wait_q  <= '0;
            req_q   <= 1'b1;
          end else begin
            req_q   <= 1'b0;
          end
        end
        PENDING: begin
          if (bus.G_PEDES) begin
            state_q  <= SERVING;
            req_q    <= 1'b0;
            urgent_q <= 1'b0;
          end else if (bus.TC_TIMEBASE && (wait_q != WAIT_MAX)) begin
            // Saturating count: the wait counter must never wrap back below MAX_WAIT.
            wait_q   <= wait_inc;
            req_q    <= 1'b1;
            urgent_q <= (wait_inc == WAIT_MAX);
          end else begin
            req_q    <= 1'b1;
            urgent_q <= (wait_q == WAIT_MAX);
          end
        end
        SERVING: begin
          req_q    <= 1'b0;
          urgent_q <= 1'b0;
          if (!bus.G_PEDES) begin
            state_q <= IDLE;
          end else begin
            state_q <= SERVING;
          end
        end
        default: begin
          state_q  <= IDLE;
          wait_q   <= '0;
          req_q    <= 1'b0;
          urgent_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PRESS  = press_q;
  assign bus.REQ    = req_q;
  assign bus.URGENT = urgent_q;

endmodule

// File: tb/tb_pedes_request.sv
// Directed bench for pedes_request: tick every 10 clocks, hand-computed cycle positions.
module tb_pedes_request;

  localparam int ST_IDLE    = 0;
  localparam int ST_SERVING = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   tcnt       = 0;
  logic last_tick  = 1'b0;
  int   pf;
  int   pcnt;
  int   req_seen;
  int   req_at40;
  int   req_at41;
  int   uf;
  int   peak;

  always #5 clk = ~clk;

  pedes_request_if bus ();

  pedes_request dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: remember whether that edge sampled a tick, then schedule the next tick.
  task automatic cyc();
    logic s;
    @(posedge clk);
    s = bus.TC_TIMEBASE;
    #1;
    last_tick = s;
    tcnt = (tcnt == 9) ? 0 : tcnt + 1;
    bus.TC_TIMEBASE = (tcnt == 9);
  endtask

  task automatic sync_tick();
    for (int k = 0; k < 12; k++) begin
      cyc();
      if (last_tick) break;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.TC_TIMEBASE = 1'b0;
    bus.BUTTON = 1'b0;
    bus.G_PEDES = 1'b0;
    repeat (3) cyc();
    chk("rst_press", bus.PRESS, 0);
    chk("rst_req", bus.REQ, 0);
    chk("rst_urgent", bus.URGENT, 0);
    chk("rst_state", int'(dut.state_q), ST_IDLE);
    rst_n = 1'b1;
    repeat (3) cyc();

    // Bounce: three 3-tick high bursts never reach DEB_TICKS.
    pcnt = 0; req_seen = 0; peak = 0;
    for (int b = 0; b < 3; b++) begin
      sync_tick();
      bus.BUTTON = 1'b1;
      for (int i = 1; i <= 30; i++) begin
        cyc();
        if (bus.PRESS) pcnt++;
        if (bus.REQ) req_seen++;
        if (i == 30) peak = int'(dut.deb_cnt_q);
      end
      bus.BUTTON = 1'b0;
      for (int i = 1; i <= 30; i++) begin
        cyc();
        if (bus.PRESS) pcnt++;
        if (bus.REQ) req_seen++;
      end
    end
    chk("bounce_peak", peak, 3);
    chk("bounce_press", pcnt, 0);
    chk("bounce_req", req_seen, 0);
    chk("bounce_cnt", int'(dut.deb_cnt_q), 0);

    // Clean press held 80 clocks, then left pending for 26 ticks.
    sync_tick();
    bus.BUTTON = 1'b1;
    pf = 0; pcnt = 0; uf = 0; req_at40 = -1; req_at41 = -1;
    for (int i = 1; i <= 300; i++) begin
      cyc();
      if (bus.PRESS) begin
        pcnt++;
        if (pf == 0) pf = i;
      end
      if (bus.URGENT && uf == 0) uf = i;
      if (i == 40) req_at40 = bus.REQ;
      if (i == 41) begin
        req_at41 = bus.REQ;
        chk("press_urgent41", bus.URGENT, 0);
      end
      if (i == 80) bus.BUTTON = 1'b0;
    end
    chk("press_first", pf, 40);
    chk("press_count", pcnt, 1);
    chk("req_at40", req_at40, 0);
    chk("req_at41", req_at41, 1);
    chk("urgent_first", uf, 240);
    chk("urgent_held", bus.URGENT, 1);
    chk("req_held", bus.REQ, 1);
    chk("wait_sat", int'(dut.wait_q), 20);

    bus.G_PEDES = 1'b1;
    cyc();
    chk("ack_req", bus.REQ, 0);
    chk("ack_urgent", bus.URGENT, 0);
    chk("ack_state", int'(dut.state_q), ST_SERVING);

    // Press during pedestrian green is never latched.
    sync_tick();
    bus.BUTTON = 1'b1;
    pf = 0; req_seen = 0;
    for (int i = 1; i <= 60; i++) begin
      cyc();
      if (bus.PRESS && pf == 0) pf = i;
      if (bus.REQ) req_seen++;
    end
    bus.BUTTON = 1'b0;
    repeat (60) begin
      cyc();
      if (bus.REQ) req_seen++;
    end
    bus.G_PEDES = 1'b0;
    repeat (20) begin
      cyc();
      if (bus.REQ) req_seen++;
    end
    chk("serve_press", pf, 40);
    chk("serve_req", req_seen, 0);
    chk("serve_idle", int'(dut.state_q), ST_IDLE);

    // PRESS and G_PEDES sampled together from IDLE: acknowledge wins.
    sync_tick();
    bus.BUTTON = 1'b1;
    pf = 0; req_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (bus.PRESS && pf == 0) pf = i;
    end
    chk("tie_press", pf, 40);
    bus.G_PEDES = 1'b1;
    repeat (10) begin
      cyc();
      if (bus.REQ) req_seen++;
    end
    chk("tie_state", int'(dut.state_q), ST_SERVING);
    chk("tie_req", req_seen, 0);
    bus.BUTTON = 1'b0;
    repeat (60) cyc();
    bus.G_PEDES = 1'b0;
    repeat (5) cyc();
    chk("tie_idle", int'(dut.state_q), ST_IDLE);

    // Reset mid-PENDING with the button held, then re-qualification.
    sync_tick();
    bus.BUTTON = 1'b1;
    repeat (41) cyc();
    chk("pre_rst_req", bus.REQ, 1);
    repeat (5) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_req", bus.REQ, 0);
    chk("rst_async_urgent", bus.URGENT, 0);
    chk("rst_async_press", bus.PRESS, 0);
    chk("rst_async_db", int'(dut.btn_db_q), 0);
    repeat (3) cyc();
    sync_tick();
    rst_n = 1'b1;
    pf = 0; req_at40 = -1; req_at41 = -1;
    for (int i = 1; i <= 41; i++) begin
      cyc();
      if (bus.PRESS && pf == 0) pf = i;
      if (i == 40) req_at40 = bus.REQ;
      if (i == 41) req_at41 = bus.REQ;
    end
    chk("rearm_press", pf, 40);
    chk("rearm_req40", req_at40, 0);
    chk("rearm_req41", req_at41, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
